// File: rtl/gpioemu_pkg.sv
// Shared definitions for the multiply/popcount coprocessor: register offsets, FSM states, STAT/CTRL bits.
// No logic of its own beyond the popcount helper.
package gpioemu_pkg;

  localparam logic [15:0] OFF_A1   = 16'h0000;
  localparam logic [15:0] OFF_A2   = 16'h0008;
  localparam logic [15:0] OFF_W    = 16'h0010;
  localparam logic [15:0] OFF_L    = 16'h0018;
  localparam logic [15:0] OFF_CTRL = 16'h0020;

  localparam int STAT_VALID = 0;
  localparam int STAT_READY = 1;
  localparam int STAT_ERR   = 2;

  localparam int CTRL_START = 0;
  localparam int CTRL_CLEAR = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MULT  = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) n = n + 6'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/gpioemu_shiftadd_mul.sv
// Iterative shift-add multiplier: OP_W cycles after start, done pulses combinationally in the last add cycle.
// A start while busy reloads the operands; the caller only starts it when idle.
module gpioemu_shiftadd_mul #(
  parameter int OP_W = 24
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              start,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              busy,
  output logic              done,
  output logic [2*OP_W-1:0] product
);

  localparam int CNT_W = $clog2(OP_W + 1);

  logic [2*OP_W-1:0] mcand;
  logic [OP_W-1:0]   mplier;
  logic [2*OP_W-1:0] acc;
  logic [CNT_W-1:0]  cnt;

  // done is asserted during the cycle whose edge performs the final add
  assign done    = busy && (cnt == CNT_W'(OP_W - 1));
  assign product = acc;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      mcand  <= {{OP_W{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/gpioemu_mulpop.sv
// Bus-mapped multiply/popcount coprocessor; result visible OP_W+2 cycles after an accepted start.
// No backpressure: starts outside IDLE are dropped and flagged in the sticky err bit.
module gpioemu_mulpop
  import gpioemu_pkg::*;
#(
  parameter int          OP_W      = 24,
  parameter int          RES_W     = 32,
  parameter logic [15:0] BASE_ADDR = 16'h0380
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [15:0] saddress,
  input  logic        srd,
  input  logic        swr,
  input  logic [31:0] sdata_in,
  output logic [31:0] sdata_out,
  input  logic [31:0] gpio_in,
  input  logic        gpio_latch,
  output logic [31:0] gpio_in_s_insp,
  output logic [31:0] gpio_out
);

  localparam int L_W = $clog2(RES_W + 1);

  logic srd_q, swr_q, latch_q;
  logic rd_rise, wr_rise, latch_rise;
  logic sel_a1, sel_a2, sel_w, sel_l, sel_ctrl;
  logic ctrl_wr, clr, start_req, start_ok;
  logic ready, cap, fin;
  logic [OP_W-1:0]   a1, a2;
  logic [RES_W-1:0]  w, res_q;
  logic [L_W-1:0]    l, pop_q;
  logic              valid, fit_q, err;
  logic [15:0]       op_count;
  logic [2*OP_W-1:0] product;
  logic [63:0]       acc_ext;
  logic              mul_busy, mul_done;
  logic [31:0]       rd_dat;
  state_t            state, state_nxt;
  logic              unused_ok;

  assign unused_ok = &{1'b0, sdata_in, mul_busy};

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      srd_q   <= 1'b0;
      swr_q   <= 1'b0;
      latch_q <= 1'b0;
    end else begin
      srd_q   <= srd;
      swr_q   <= swr;
      latch_q <= gpio_latch;
    end
  end

  assign rd_rise    = srd & ~srd_q;
  assign wr_rise    = swr & ~swr_q;
  assign latch_rise = gpio_latch & ~latch_q;

  assign sel_a1   = (saddress == BASE_ADDR + OFF_A1);
  assign sel_a2   = (saddress == BASE_ADDR + OFF_A2);
  assign sel_w    = (saddress == BASE_ADDR + OFF_W);
  assign sel_l    = (saddress == BASE_ADDR + OFF_L);
  assign sel_ctrl = (saddress == BASE_ADDR + OFF_CTRL);

  assign ctrl_wr   = wr_rise & sel_ctrl;
  assign clr       = ctrl_wr & sdata_in[CTRL_CLEAR];
  assign start_req = ctrl_wr & sdata_in[CTRL_START];
  assign start_ok  = start_req & (state == IDLE);

  gpioemu_shiftadd_mul #(.OP_W(OP_W)) u_mul (
    .clk     (clk),
    .n_reset (n_reset),
    .start   (start_ok),
    .a       (a1),
    .b       (a2),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (product)
  );

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = MULT;
      MULT:    if (mul_done) state_nxt = COUNT;
      COUNT:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    cap   = 1'b0;
    fin   = 1'b0;
    case (state)
      IDLE:    ready = 1'b1;
      COUNT:   cap   = 1'b1;
      DONE:    fin   = 1'b1;
      default: ;
    endcase
  end

  // Widened so the overflow test degenerates cleanly to 1 when 2*OP_W <= RES_W
  assign acc_ext = 64'(product);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      a1       <= '0;
      a2       <= '0;
      res_q    <= '0;
      pop_q    <= '0;
      fit_q    <= 1'b1;
      w        <= '0;
      l        <= '0;
      valid    <= 1'b1;
      err      <= 1'b0;
      op_count <= '0;
    end else begin
      if (wr_rise && sel_a1) a1 <= sdata_in[OP_W-1:0];
      if (wr_rise && sel_a2) a2 <= sdata_in[OP_W-1:0];
      if (cap) begin
        res_q <= acc_ext[RES_W-1:0];
        pop_q <= L_W'(popcount(32'(acc_ext[RES_W-1:0])));
        fit_q <= ((acc_ext >> RES_W) == 64'd0);
      end
      if (fin) begin
        w <= res_q;
        l <= pop_q;
      end
      if (start_ok) valid <= 1'b1;
      else if (fin) valid <= fit_q;
      // clear is applied before the start, so a rejected start in the same write still flags err
      err      <= (err & ~clr) | (start_req & ~start_ok);
      op_count <= (clr ? 16'h0000 : op_count) + {15'b0, fin};
    end
  end

  always_comb begin
    rd_dat = 32'h0;
    if (sel_a1)   rd_dat = 32'(a1);
    if (sel_a2)   rd_dat = 32'(a2);
    if (sel_w)    rd_dat = 32'(w);
    if (sel_l)    rd_dat = 32'(l);
    if (sel_ctrl) rd_dat = {29'b0, err, ready, valid};
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sdata_out      <= '0;
      gpio_in_s_insp <= '0;
    end else begin
      if (rd_rise)    sdata_out      <= rd_dat;
      if (latch_rise) gpio_in_s_insp <= gpio_in;
    end
  end

  assign gpio_out = {16'h0000, op_count};

endmodule

// File: tb/tb_gpioemu_mulpop.sv
// Randomised scoreboard bench for gpioemu_mulpop against an arithmetic reference model.
// Reads push expectations; a monitor compares sdata_out after each srd rising edge.
module tb_gpioemu_mulpop;

  localparam int          OP_W  = 24;
  localparam int          RES_W = 32;
  localparam logic [15:0] BASE  = 16'h0380;
  localparam logic [15:0] R_A1 = 16'h00, R_A2 = 16'h08, R_W = 16'h10, R_L = 16'h18, R_CT = 16'h20;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic [15:0] saddress = '0;
  logic        srd = 1'b0, swr = 1'b0, gpio_latch = 1'b0;
  logic [31:0] sdata_in = '0, gpio_in = '0;
  logic [31:0] sdata_out, gpio_in_s_insp, gpio_out;

  gpioemu_mulpop #(.OP_W(OP_W), .RES_W(RES_W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .n_reset(n_reset), .saddress(saddress), .srd(srd), .swr(swr),
    .sdata_in(sdata_in), .sdata_out(sdata_out), .gpio_in(gpio_in),
    .gpio_latch(gpio_latch), .gpio_in_s_insp(gpio_in_s_insp), .gpio_out(gpio_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];

  // reference model state
  logic [23:0] m_a1, m_a2, m_pa, m_pb;
  logic [31:0] m_w;
  int          m_l;
  bit          m_valid, m_err, m_busy;
  logic [15:0] m_cnt;
  logic [31:0] m_insp;
  int          t_start;

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic model_reset();
    m_a1 = 0; m_a2 = 0; m_pa = 0; m_pb = 0; m_w = 0; m_l = 0;
    m_valid = 1; m_err = 0; m_busy = 0; m_cnt = 0; m_insp = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [15:0] off);
    case (off)
      R_A1:    return 32'(m_a1);
      R_A2:    return 32'(m_a2);
      R_W:     return m_w;
      R_L:     return 32'(m_l);
      R_CT:    return {29'b0, m_err, ~m_busy, m_valid};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_write(input logic [15:0] off, input logic [31:0] d, output bit acc);
    acc = 0;
    case (off)
      R_A1: m_a1 = d[23:0];
      R_A2: m_a2 = d[23:0];
      R_CT: begin
        if (d[1]) begin m_err = 0; m_cnt = 0; end
        if (d[0]) begin
          if (m_busy) m_err = 1;
          else begin
            m_busy = 1; m_valid = 1; m_pa = m_a1; m_pb = m_a2; acc = 1;
          end
        end
      end
      default: ;
    endcase
  endtask

  task automatic model_complete();
    logic [63:0] p;
    p = 64'(m_pa) * 64'(m_pb);
    m_w = p[31:0];
    m_l = $countones(p[31:0]);
    m_valid = (p >> RES_W) == 64'd0;
    m_cnt = m_cnt + 16'd1;
    m_busy = 0;
  endtask

  task automatic wr(input logic [15:0] off, input logic [31:0] d);
    bit acc;
    saddress = BASE + off; sdata_in = d; swr = 1'b1;
    model_write(off, d, acc);
    @(negedge clk);
    if (acc) t_start = cyc;
    swr = 1'b0;
    @(negedge clk);
  endtask

  task automatic rd(input logic [15:0] off, input string n);
    saddress = BASE + off; srd = 1'b1;
    exp_q.push_back(model_read(off));
    name_q.push_back(n);
    @(negedge clk);
    srd = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_done();
    wait_until(t_start + OP_W + 2);
    model_complete();
  endtask

  task automatic read_results(input string tag);
    rd(R_W, {tag, "_W"});
    rd(R_L, {tag, "_L"});
    rd(R_CT, {tag, "_STAT"});
    check({tag, "_gpio_out"}, gpio_out, {16'h0, m_cnt});
  endtask

  // monitor: DUT captures read data at the edge where srd rises
  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (srd && !prev && n_reset) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL rd_unexpected: got %h expected no read", sdata_out);
        end else check(name_q.pop_front(), sdata_out, exp_q.pop_front());
      end
      prev = srd;
    end
  end

  function automatic logic [23:0] pick_op();
    case ($urandom_range(0, 3))
      0:       return 24'($urandom);
      1:       return 24'($urandom_range(0, 255));
      2:       return 24'hFFFFFF;
      default: return 24'($urandom_range(0, 1));
    endcase
  endfunction

  initial begin
    logic [23:0] ra, rb;
    model_reset();
    repeat (3) @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);

    // reset state
    rd(R_A1, "rst_A1"); rd(R_A2, "rst_A2"); rd(R_W, "rst_W"); rd(R_L, "rst_L");
    rd(R_CT, "rst_STAT"); rd(16'h04, "rst_gap"); rd(16'h28, "rst_beyond");
    check("rst_gpio_out", gpio_out, 32'h0);
    check("rst_insp", gpio_in_s_insp, 32'h0);

    // 3 * 5
    wr(R_A1, 32'h3); wr(R_A2, 32'h5); wr(R_CT, 32'h1);
    rd(R_CT, "small_busy_STAT");
    wait_done();
    read_results("small");

    // overflow case, then clear
    wr(R_A1, 32'hFFFFFF); wr(R_A2, 32'hFFFFFF); wr(R_CT, 32'h1);
    wait_done();
    read_results("ovf");
    wr(R_CT, 32'h2);
    check("ovf_clear_gpio_out", gpio_out, {16'h0, m_cnt});
    rd(R_CT, "ovf_clear_STAT");

    // rejected start and operand snapshot
    wr(R_A1, 32'h3); wr(R_A2, 32'h5); wr(R_CT, 32'h1);
    wait_until(t_start + 5);
    wr(R_A1, 32'h0); wr(R_CT, 32'h1);
    rd(R_CT, "rej_busy_STAT");
    wait_done();
    read_results("rej");
    rd(R_A1, "rej_A1");
    wr(R_CT, 32'h2);
    rd(R_CT, "rej_clear_STAT");

    // start landing on the DONE->IDLE edge is rejected
    wr(R_A1, 32'h7); wr(R_A2, 32'h9); wr(R_CT, 32'h1);
    wait_until(t_start + OP_W + 1);
    wr(R_CT, 32'h1);
    model_complete();
    read_results("coll");
    wr(R_CT, 32'h2);

    // read and write of A1 in the same cycle
    saddress = BASE + R_A1; sdata_in = 32'h00ABCDEF; srd = 1'b1; swr = 1'b1;
    exp_q.push_back(model_read(R_A1)); name_q.push_back("rw_old_A1");
    m_a1 = 24'hABCDEF;
    @(negedge clk); srd = 1'b0; swr = 1'b0; @(negedge clk);
    rd(R_A1, "rw_new_A1");

    // gpio capture on rising edge only
    gpio_in = 32'hA5A5_0001; gpio_latch = 1'b1;
    @(negedge clk);
    m_insp = 32'hA5A5_0001;
    check("latch_capture", gpio_in_s_insp, m_insp);
    gpio_in = 32'h1234_5678;
    @(negedge clk);
    check("latch_level_hold", gpio_in_s_insp, m_insp);
    gpio_latch = 1'b0; gpio_in = 32'hFFFF_0000;
    repeat (2) @(negedge clk);
    check("latch_low_hold", gpio_in_s_insp, m_insp);

    // randomised operations
    for (int i = 0; i < 12; i++) begin
      ra = pick_op(); rb = pick_op();
      wr(R_A1, 32'(ra)); wr(R_A2, 32'(rb));
      wr(R_CT, ($urandom_range(0, 1) != 0) ? 32'h3 : 32'h1);
      rd(R_CT, "rnd_busy_STAT");
      if ($urandom_range(0, 1) != 0) wr(R_A2, $urandom);
      wait_done();
      read_results("rnd");
    end

    // reset in the middle of an operation
    wr(R_A1, 32'h123); wr(R_A2, 32'h456); wr(R_CT, 32'h1);
    wait_until(t_start + 10);
    n_reset = 1'b0;
    #1;
    model_reset();
    check("mrst_gpio_out", gpio_out, {16'h0, m_cnt});
    check("mrst_sdata_out", sdata_out, 32'h0);
    check("mrst_insp", gpio_in_s_insp, m_insp);
    @(negedge clk);
    n_reset = 1'b1;
    repeat (OP_W + 6) @(negedge clk);
    check("mrst_idle_gpio_out", gpio_out, {16'h0, m_cnt});
    rd(R_CT, "mrst_STAT"); rd(R_W, "mrst_W"); rd(R_L, "mrst_L"); rd(R_A1, "mrst_A1");

    repeat (4) @(negedge clk);
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain: got %0d pending reads expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpioemu_mulpop.md
# gpioemu_mulpop

Parametrised multiply/popcount coprocessor for the GPIO emulator bus, successor to the fixed 24-bit unit. It takes two operands over the `saddress`/`srd`/`swr` register bus and multiplies them with an iterative shift-add datapath. It flags overflow beyond the result width, counts ones in the result, and drives a wrapping completion counter on `gpio_out`. Bus strobes are sampled synchronously to `clk`, and operands are snapshotted at start.

## Interface
- `OP_W`, 24: operand width (1..32); a bus write keeps `sdata_in[OP_W-1:0]`.
- `RES_W`, 32: result register width (1..32).
- `BASE_ADDR`, 16'h0380: base of the register window.
- `clk`  in  1  single clock; everything is on the rising edge.
- `n_reset`  in  1  asynchronous active-low reset.
- `saddress`  in  16  register address.
- `srd`  in  1  read strobe, synchronous level; acts on its rising edge (high now, low last cycle).
- `swr`  in  1  write strobe; same edge rule as `srd`.
- `sdata_in`  in  32  write data.
- `sdata_out`  out  32  registered read data; holds until the next read.
- `gpio_in`  in  32  external input.
- `gpio_latch`  in  1  capture strobe, synchronous; captures on its rising edge.
- `gpio_in_s_insp`  out  32  last captured `gpio_in`.
- `gpio_out`  out  32  `{16'h0, op_count}`.

## Operation
- Register map, as offsets from `BASE_ADDR`:
  - +0x00 A1: read/write.
  - +0x08 A2: read/write.
  - +0x10 W: read-only, result `[RES_W-1:0]`, zero-extended.
  - +0x18 L: read-only, popcount of W, zero-extended.
  - +0x20 CTRL/STAT: read/write.
  - Any other address reads 0; writes to it are ignored.
- STAT read value is `{29'b0, err, ready, valid}`.
  - `ready`: set when idle.
  - `valid`: set when the last product fit in RES_W bits.
  - `err`: sticky; set when a start is rejected.
- CTRL write:
  - `data[1]=1` clears `err` and `op_count`.
  - `data[0]=1` starts an operation.
  - If both bits are set, the clear happens first, then the start.
- Start is accepted only in IDLE. A start in any other state is ignored and sets `err`.
- On an accepted start:
  - A1 and A2 are snapshotted into the datapath.
  - `ready`←0 and `valid`←1.
  - Later writes to A1/A2 change the registers but do not affect the running operation.
- State machine: IDLE → MULT → COUNT → DONE → IDLE.
  - MULT: OP_W cycles. Each cycle, if multiplier bit i is set, the shifted multiplicand is added into a 2·OP_W-bit accumulator.
  - COUNT: one cycle. Computes `valid = (acc[2·OP_W-1:RES_W] == 0)`; this is 1 whenever 2·OP_W ≤ RES_W. Computes the popcount of `acc[RES_W-1:0]`.
  - DONE: one cycle. W and L update; `ready`←1; `op_count`+1, wrapping 0xFFFF→0x0000.
- W and L hold their previous values until DONE.
- L width is `$clog2(RES_W+1)`.
- Reset, including mid-operation, returns the block to IDLE. Reset values:
  - W=0, L=0.
  - A1=0, A2=0.
  - `ready`=1, `valid`=1, `err`=0.
  - `op_count`=0, so `gpio_out`=0.
  - `sdata_out`=0, `gpio_in_s_insp`=0.
- `srd` and `swr` edges in the same cycle are both serviced. Read data reflects register contents from before that cycle's write.

## Timing
- Start edge at clock k: state goes to MULT at edge k.
  - COUNT at edge k+OP_W.
  - DONE at edge k+OP_W+1.
  - IDLE at edge k+OP_W+2, where W, L, STAT and `gpio_out` update.
- Total latency is OP_W+2 cycles; 26 at the default parameters.
- `sdata_out` is valid one cycle after the `srd` rising-edge cycle.
- STAT reads during MULT, COUNT or DONE return `ready`=0.
- A start in the same cycle that DONE→IDLE completes is rejected, because state is not yet IDLE.
- `gpio_in_s_insp` updates one cycle after the `gpio_latch` rising-edge cycle.

## Structure
- Package `gpioemu_pkg` holds:
  - register offset localparams;
  - the state enum (IDLE, MULT, COUNT, DONE);
  - STAT bit positions;
  - a `popcount` function.
- Sub-module `gpioemu_shiftadd_mul`, parametrised by OP_W:
  - inputs: start, a, b;
  - outputs: busy, done pulse, product.
- Top level contains the bus decode, strobe edge detectors, FSM, status and counter.

## Test plan
- Reset, then read every register: all return 0 except STAT, which returns 0x3. `gpio_out`=0.
- A1=0x000003, A2=0x000005, CTRL=0x1; wait 26 cycles: W=0xF, L=4, STAT=0x3, `gpio_out`=1.
- A1=A2=0xFFFFFF, start: W=0xFE000001, L=8, STAT=0x2. A following CTRL=0x2 write gives `gpio_out`=0.
- Start, then at cycle 5 write A1=0 and CTRL=0x1:
  - original operands complete in 26 cycles;
  - STAT=0x7, showing `err` set.
  - CTRL=0x2 then gives STAT=0x3.
- Assert `n_reset` at cycle 10 of an operation: all outputs return to reset values and the FSM restarts only on a new start.
- `gpio_in`=0xA5A5_0001 with a `gpio_latch` pulse: `gpio_in_s_insp`=0xA5A5_0001 one cycle later, and it holds when `gpio_in` later changes.
